// File: rtl/difftest_uart_port_if.sv
// Signal bundle between the console MMIO logic / difftest endpoint (master)
// and the UART port (slave).
interface difftest_uart_port_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic [CW-1:0] tx_count;

    logic          rx_req;
    logic          rx_req_ready;
    logic          rx_resp_valid;
    logic [7:0]    rx_resp_data;
    logic          rx_resp_empty;

    logic          uart_out_valid;
    logic [7:0]    uart_out_ch;
    logic          uart_in_valid;
    logic [7:0]    uart_in_ch;

    modport master (
        output tx_valid, tx_data, rx_req, uart_in_ch,
        input  tx_ready, tx_count, rx_req_ready, rx_resp_valid, rx_resp_data,
               rx_resp_empty, uart_out_valid, uart_out_ch, uart_in_valid
    );

    modport slave (
        input  tx_valid, tx_data, rx_req, uart_in_ch,
        output tx_ready, tx_count, rx_req_ready, rx_resp_valid, rx_resp_data,
               rx_resp_empty, uart_out_valid, uart_out_ch, uart_in_valid
    );
endinterface

// File: rtl/difftest_uart_port.sv
// Difftest console UART port: paced TX FIFO towards uart_out, and a
// request/poll/response RX path on uart_in. TX and RX are independent.
module difftest_uart_port #(
    parameter int DEPTH = 8,
    parameter int GAP   = 0
) (
    input logic                 clock,
    input logic                 reset,
    difftest_uart_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_REQ, RX_RESP} rx_state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          active_reg;
    logic          tx_ready;
    logic          push;
    logic          pop;

    tx_state_t     tx_state_reg;
    tx_state_t     tx_state_next;
    logic [GW-1:0] gap_reg;
    logic [GW-1:0] gap_next;
    logic          out_valid_reg;
    logic          out_valid_next;
    logic [7:0]    out_ch_reg;

    rx_state_t     rx_state_reg;
    rx_state_t     rx_state_next;
    logic          rx_req_ready;
    logic          in_valid_reg;
    logic          in_valid_next;
    logic          resp_valid_reg;
    logic          resp_valid_next;
    logic [7:0]    resp_data_reg;
    logic [7:0]    resp_data_next;

    // active_reg holds both ready outputs low through reset and its release cycle
    assign tx_ready = active_reg && (count_reg < CW'(DEPTH));
    assign push     = bus.tx_valid && tx_ready;

    // ---------------- TX next state ----------------
    // A WAIT that has counted down pops directly, so pulses are GAP+1 apart.
    always_comb begin
        tx_state_next = tx_state_reg;
        gap_next      = gap_reg;
        pop           = 1'b0;
        unique case (tx_state_reg)
            TX_IDLE: begin
                if (count_reg != '0) begin
                    pop           = 1'b1;
                    tx_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (GAP == 0) begin
                    if (count_reg != '0) begin
                        pop           = 1'b1;
                        tx_state_next = TX_SEND;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end else begin
                    gap_next      = GW'(GAP - 1);
                    tx_state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (gap_reg != '0) begin
                    gap_next = gap_reg - GW'(1);
                end else if (count_reg != '0) begin
                    pop           = 1'b1;
                    tx_state_next = TX_SEND;
                end else begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // ---------------- TX outputs / occupancy ----------------
    always_comb begin
        out_valid_next = pop;
        count_next     = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr_reg] <= bus.tx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            active_reg    <= 1'b0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            tx_state_reg  <= TX_IDLE;
            gap_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
        end else begin
            active_reg    <= 1'b1;
            count_reg     <= count_next;
            tx_state_reg  <= tx_state_next;
            gap_reg       <= gap_next;
            out_valid_reg <= out_valid_next;
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg   <= rptr_reg + AW'(1);
                out_ch_reg <= mem[rptr_reg];
            end
        end
    end

    // ---------------- RX FSM ----------------
    assign rx_req_ready = active_reg && (rx_state_reg == RX_IDLE);

    always_comb begin
        rx_state_next = rx_state_reg;
        unique case (rx_state_reg)
            RX_IDLE: if (bus.rx_req && rx_req_ready) rx_state_next = RX_REQ;
            RX_REQ:  rx_state_next = RX_RESP;
            RX_RESP: rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        in_valid_next   = (rx_state_next == RX_REQ);
        resp_valid_next = (rx_state_next == RX_RESP);
        resp_data_next  = resp_data_reg;
        if (rx_state_reg == RX_REQ) begin
            resp_data_next = bus.uart_in_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state_reg   <= RX_IDLE;
            in_valid_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            rx_state_reg   <= rx_state_next;
            in_valid_reg   <= in_valid_next;
            resp_valid_reg <= resp_valid_next;
            resp_data_reg  <= resp_data_next;
        end
    end

    assign bus.tx_ready       = tx_ready;
    assign bus.tx_count       = count_reg;
    assign bus.rx_req_ready   = rx_req_ready;
    assign bus.rx_resp_valid  = resp_valid_reg;
    assign bus.rx_resp_data   = resp_data_reg;
    assign bus.rx_resp_empty  = (resp_data_reg == 8'hff);
    assign bus.uart_out_valid = out_valid_reg;
    assign bus.uart_out_ch    = out_ch_reg;
    assign bus.uart_in_valid  = in_valid_reg;
endmodule

// File: tb/tb_difftest_uart_port.sv
// Directed bench for difftest_uart_port: one instance with GAP=0, one with
// GAP=3, sharing clock and reset; sel routes stimulus to one of them.
module tb_difftest_uart_port;
    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       rx_req;
    logic [7:0] uart_in_ch;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    difftest_uart_port_if #(.DEPTH(8)) if0 ();
    difftest_uart_port_if #(.DEPTH(8)) if3 ();

    assign if0.tx_valid   = tx_valid & ~sel;
    assign if3.tx_valid   = tx_valid & sel;
    assign if0.tx_data    = tx_data;
    assign if3.tx_data    = tx_data;
    assign if0.rx_req     = rx_req & ~sel;
    assign if3.rx_req     = rx_req & sel;
    assign if0.uart_in_ch = uart_in_ch;
    assign if3.uart_in_ch = uart_in_ch;

    difftest_uart_port #(.DEPTH(8), .GAP(0)) dut0 (.clock(clk), .reset(reset), .bus(if0));
    difftest_uart_port #(.DEPTH(8), .GAP(3)) dut3 (.clock(clk), .reset(reset), .bus(if3));

    logic       o_tx_ready;
    logic [3:0] o_tx_count;
    logic       o_out_valid;
    logic [7:0] o_out_ch;

    assign o_tx_ready  = sel ? if3.tx_ready       : if0.tx_ready;
    assign o_tx_count  = sel ? if3.tx_count       : if0.tx_count;
    assign o_out_valid = sel ? if3.uart_out_valid : if0.uart_out_valid;
    assign o_out_ch    = sel ? if3.uart_out_ch    : if0.uart_out_ch;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer bytes 0..n-1 continuously; check order, pulse spacing and peak occupancy.
    task automatic run_burst(input int n, input int sp, input int exp_max);
        int sent;
        int got;
        int last;
        int maxc;
        bit full_seen;
        sent = 0; got = 0; last = 0; maxc = 0; full_seen = 0;
        for (int k = 0; k < 300 && got < n; k++) begin
            if (o_out_valid) begin
                $display("burst byte %0d = %02h at cycle %0d", got, o_out_ch, k);
                check_val("burst_order", o_out_ch, got);
                if (got > 0) check_val("burst_spacing", k - last, sp);
                last = k;
                got++;
            end
            if (int'(o_tx_count) > maxc) maxc = int'(o_tx_count);
            if (o_tx_count == 4'd8 && !full_seen) begin
                full_seen = 1;
                check_val("full_ready", o_tx_ready, 0);
            end
            tx_valid = (sent < n);
            tx_data  = 8'(sent);
            if (tx_valid && o_tx_ready) sent++;
            tick(1);
        end
        tx_valid = 1'b0;
        check_val("burst_count", got, n);
        check_val("burst_sent", sent, n);
        check_val("burst_max_occ", maxc, exp_max);
        tick(2);
        check_val("burst_drain", o_tx_count, 0);
    endtask

    task automatic rx_case(input logic [7:0] ch, input logic exp_empty);
        int extra;
        uart_in_ch = ch;
        rx_req     = 1'b1;
        check_val("rx_ready_idle", if0.rx_req_ready, 1);
        tick(1);
        check_val("rx_in_valid", if0.uart_in_valid, 1);
        check_val("rx_ready_busy", if0.rx_req_ready, 0);
        check_val("rx_early_resp", if0.rx_resp_valid, 0);
        tick(1);
        rx_req = 1'b0;
        $display("rx response valid=%0b data=%02h empty=%0b", if0.rx_resp_valid, if0.rx_resp_data, if0.rx_resp_empty);
        check_val("rx_resp_valid", if0.rx_resp_valid, 1);
        check_val("rx_resp_data", if0.rx_resp_data, ch);
        check_val("rx_resp_empty", if0.rx_resp_empty, exp_empty);
        check_val("rx_in_valid_off", if0.uart_in_valid, 0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (if0.rx_resp_valid) extra++;
        end
        check_val("rx_single_resp", extra, 0);
        check_val("rx_ready_back", if0.rx_req_ready, 1);
    endtask

    initial begin
        int np;
        int exp_t [3];
        int pulses;
        exp_t = '{2, 6, 10};

        // Reset held with requests active
        sel = 1'b0; reset = 1'b0; tx_valid = 1'b1; tx_data = 8'h77; rx_req = 1'b1; uart_in_ch = 8'h00;
        tick(3);
        check_val("rst_tx_ready", if0.tx_ready, 0);
        check_val("rst_tx_count", if0.tx_count, 0);
        check_val("rst_rx_req_ready", if0.rx_req_ready, 0);
        check_val("rst_resp_valid", if0.rx_resp_valid, 0);
        check_val("rst_resp_data", if0.rx_resp_data, 0);
        check_val("rst_resp_empty", if0.rx_resp_empty, 0);
        check_val("rst_out_valid", if0.uart_out_valid, 0);
        check_val("rst_out_ch", if0.uart_out_ch, 0);
        check_val("rst_in_valid", if0.uart_in_valid, 0);
        check_val("rst_tx_count3", if3.tx_count, 0);
        reset = 1'b1; tx_valid = 1'b0; rx_req = 1'b0;
        tick(1);
        check_val("rel_tx_ready", if0.tx_ready, 1);
        check_val("rel_rx_req_ready", if0.rx_req_ready, 1);
        check_val("rel_tx_count", if0.tx_count, 0);
        check_val("rel_out_valid", if0.uart_out_valid, 0);

        // Single byte, GAP=0
        tx_valid = 1'b1; tx_data = 8'h41;
        check_val("single_ready", o_tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
        check_val("single_c1_count", o_tx_count, 1);
        check_val("single_c1_valid", o_out_valid, 0);
        tick(1);
        $display("single byte out valid=%0b ch=%02h", o_out_valid, o_out_ch);
        check_val("single_c2_valid", o_out_valid, 1);
        check_val("single_c2_ch", o_out_ch, 8'h41);
        check_val("single_c2_count", o_tx_count, 0);
        tick(1);
        check_val("single_c3_valid", o_out_valid, 0);

        // Burst of 10, GAP=0: contiguous, occupancy never above 1
        run_burst(10, 1, 1);

        // Pacing, GAP=3
        sel = 1'b1;
        tick(1);
        np = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_out_valid) begin
                $display("paced byte %0d = %02h at cycle %0d", np, o_out_ch, k);
                if (np < 3) begin
                    check_val("pace_ch", o_out_ch, 8'h10 + 8'(np));
                    check_val("pace_time", k, exp_t[np]);
                end
                np++;
            end
            tx_valid = (k < 3);
            tx_data  = 8'h10 + 8'(k);
            tick(1);
        end
        tx_valid = 1'b0;
        check_val("pace_pulses", np, 3);

        // Burst of 12, GAP=3: fills the FIFO and stalls
        run_burst(12, 4, 8);

        // RX on the GAP=0 instance
        sel = 1'b0;
        tick(1);
        rx_case(8'hff, 1'b1);
        rx_case(8'h61, 1'b0);

        // Reset while SEND is active with 5 bytes queued (GAP=3)
        sel = 1'b1;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            tx_valid = (k < 8);
            tx_data  = 8'h20 + 8'(k);
            tick(1);
        end
        tx_valid = 1'b0;
        check_val("mid_send_valid", o_out_valid, 1);
        check_val("mid_send_ch", o_out_ch, 8'h22);
        check_val("mid_occ", o_tx_count, 5);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check_val("mid_rst_count", o_tx_count, 0);
        check_val("mid_rst_valid", o_out_valid, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (o_out_valid) pulses++;
        end
        check_val("mid_no_output", pulses, 0);
        check_val("mid_count_zero", o_tx_count, 0);
        tx_valid = 1'b1; tx_data = 8'h55;
        check_val("mid_new_ready", o_tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
        check_val("mid_new_c1_valid", o_out_valid, 0);
        tick(1);
        $display("post-reset byte valid=%0b ch=%02h", o_out_valid, o_out_ch);
        check_val("mid_new_valid", o_out_valid, 1);
        check_val("mid_new_ch", o_out_ch, 8'h55);
        tick(1);
        check_val("mid_new_off", o_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end
endmodule
